// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the five-stage pipeline.
// Registers the rs1/rs2 forward selects for the instruction entering EX and
// produces same-cycle stall/bubble/flush/freeze controls. Saturating counters
// record load-use stalls and branch flushes for performance debug.
//
// Control handshake: there is no valid/ready pair here. Every control output
// is a level that applies to the current cycle only. mem_busy has absolute
// priority and holds every pipeline register, including this block's own
// state. While rst_n is low, all combinational controls are forced to 0.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  regwen_ex,
    input  logic                  memread_ex,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  regwen_m,
    input  logic                  branch_taken_ex,
    input  logic                  mem_busy,
    output logic [FWD_W-1:0]      forward_1,
    output logic [FWD_W-1:0]      forward_2,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic                  freeze,
    output logic [CNT_W-1:0]      ldstall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FRZ     = 2'd2
    } state_t;

    // 10 selects the result sitting in MEM, 01 the result sitting in WB.
    localparam logic [FWD_W-1:0] FWD_NONE = '0;
    localparam logic [FWD_W-1:0] FWD_MEM  = FWD_W'(2'b10);
    localparam logic [FWD_W-1:0] FWD_WB   = FWD_W'(2'b01);

    state_t state;
    state_t saved_state;

    logic ex_hit_1, ex_hit_2;
    logic m_hit_1, m_hit_2;
    logic load_use;
    logic do_freeze, do_flush, do_ldstall;
    logic [FWD_W-1:0] fwd_next_1, fwd_next_2;

    // A producer matches a source only if it writes a non-zero rd that the
    // consumer actually reads; x0 is hard-wired and never forwarded.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic                  wen,
                                       input logic                  used);
        return wen && used && (rd != '0) && (rd == src);
    endfunction

    // EX producer is younger than MEM producer, so an EX match wins.
    function automatic logic [FWD_W-1:0] pick_fwd(input logic ex_hit,
                                                  input logic m_hit);
        if (ex_hit) begin
            return FWD_MEM;
        end else if (m_hit) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    // Hazard detection and priority resolution for the current cycle.
    always_comb begin
        ex_hit_1   = reg_match(rs1_id, rd_ex, regwen_ex, rs1_used_id);
        ex_hit_2   = reg_match(rs2_id, rd_ex, regwen_ex, rs2_used_id);
        m_hit_1    = reg_match(rs1_id, rd_m, regwen_m, rs1_used_id);
        m_hit_2    = reg_match(rs2_id, rd_m, regwen_m, rs2_used_id);
        load_use   = memread_ex && (ex_hit_1 || ex_hit_2);
        fwd_next_1 = pick_fwd(ex_hit_1, m_hit_1);
        fwd_next_2 = pick_fwd(ex_hit_2, m_hit_2);
        // A taken branch squashes the consumer, so it masks any load-use.
        do_freeze  = rst_n && mem_busy;
        do_flush   = rst_n && !mem_busy && branch_taken_ex;
        do_ldstall = rst_n && !mem_busy && !branch_taken_ex && load_use;
    end

    // Pipeline control outputs are pure functions of this cycle's inputs.
    always_comb begin
        freeze      = do_freeze;
        flush_ifid  = do_flush;
        stall_pc    = do_ldstall;
        stall_ifid  = do_ldstall;
        bubble_idex = do_flush || do_ldstall;
        state_dbg   = state;
    end

    // Forward selects, FSM and saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            forward_1   <= FWD_NONE;
            forward_2   <= FWD_NONE;
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            ldstall_cnt <= '0;
            flush_cnt   <= '0;
        end else if (mem_busy) begin
            // Everything holds; only remember where to resume.
            if (state != ST_FRZ) begin
                saved_state <= state;
                state       <= ST_FRZ;
            end
        end else begin
            if (branch_taken_ex) begin
                forward_1 <= FWD_NONE;
                forward_2 <= FWD_NONE;
                if (flush_cnt != '1) begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                end
            end else if (load_use) begin
                forward_1 <= FWD_NONE;
                forward_2 <= FWD_NONE;
                if (ldstall_cnt != '1) begin
                    ldstall_cnt <= ldstall_cnt + CNT_W'(1);
                end
            end else begin
                forward_1 <= fwd_next_1;
                forward_2 <= fwd_next_2;
            end

            case (state)
                ST_RUN: begin
                    if (load_use && !branch_taken_ex) begin
                        state <= ST_LDSTALL;
                    end
                end
                ST_LDSTALL: state <= ST_RUN;
                ST_FRZ:     state <= saved_state;
                default:    state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_LDSTALL = 2'd1;
    localparam logic [1:0] S_FRZ     = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex, rd_m;
    logic        rs1_used_id, rs2_used_id;
    logic        regwen_ex, memread_ex, regwen_m;
    logic        branch_taken_ex, mem_busy;
    logic [1:0]  forward_1, forward_2;
    logic        stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze;
    logic [15:0] ldstall_cnt, flush_cnt;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_ex           (rd_ex),
        .regwen_ex       (regwen_ex),
        .memread_ex      (memread_ex),
        .rd_m            (rd_m),
        .regwen_m        (regwen_m),
        .branch_taken_ex (branch_taken_ex),
        .mem_busy        (mem_busy),
        .forward_1       (forward_1),
        .forward_2       (forward_2),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .bubble_idex     (bubble_idex),
        .flush_ifid      (flush_ifid),
        .freeze          (freeze),
        .ldstall_cnt     (ldstall_cnt),
        .flush_cnt       (flush_cnt),
        .state_dbg       (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        rd_ex = 5'd0; regwen_ex = 1'b0; memread_ex = 1'b0;
        rd_m = 5'd0; regwen_m = 1'b0;
        branch_taken_ex = 1'b0; mem_busy = 1'b0;
    endtask

    // controls: {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze}
    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze}, {27'd0, exp});
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // reset with hazards present: controls forced low
        mem_busy = 1'b1; branch_taken_ex = 1'b1;
        chk_ctrl("rst_ctrl_forced_low", 5'b00000);
        tick();
        chk("rst_fwd1", forward_1, 2'b00);
        chk("rst_fwd2", forward_2, 2'b00);
        chk("rst_state", state_dbg, S_RUN);
        chk("rst_ldcnt", ldstall_cnt, 16'd0);
        chk("rst_flcnt", flush_cnt, 16'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // back-to-back ALU: EX add x5, ID reads x5 and x6
        rd_ex = 5'd5; regwen_ex = 1'b1;
        rs1_id = 5'd5; rs1_used_id = 1'b1; rs2_id = 5'd6; rs2_used_id = 1'b1;
        chk_ctrl("alu_no_stall", 5'b00000);
        tick();
        chk("alu_fwd1", forward_1, 2'b10);
        chk("alu_fwd2", forward_2, 2'b00);

        // distance two: MEM writes x7, EX writes x3, ID rs2=x7
        idle();
        rd_m = 5'd7; regwen_m = 1'b1; rd_ex = 5'd3; regwen_ex = 1'b1;
        rs1_id = 5'd1; rs1_used_id = 1'b1; rs2_id = 5'd7; rs2_used_id = 1'b1;
        tick();
        chk("dist2_fwd1", forward_1, 2'b00);
        chk("dist2_fwd2", forward_2, 2'b01);
        // both EX and MEM write x7: EX wins
        rd_ex = 5'd7;
        tick();
        chk("both_fwd2_ex_wins", forward_2, 2'b10);
        // rs2 not actually read: no forward
        rs2_used_id = 1'b0;
        tick();
        chk("unused_src_fwd2", forward_2, 2'b00);

        // load-use: EX lw x4, ID rs1=x4
        idle();
        rd_ex = 5'd4; regwen_ex = 1'b1; memread_ex = 1'b1;
        rs1_id = 5'd4; rs1_used_id = 1'b1;
        chk_ctrl("lu_ctrl", 5'b11100);
        tick();
        chk("lu_ldcnt", ldstall_cnt, 16'd1);
        chk("lu_state", state_dbg, S_LDSTALL);
        chk("lu_fwd1", forward_1, 2'b00);
        // bubble in EX, load in MEM, consumer still in ID
        idle();
        rd_m = 5'd4; regwen_m = 1'b1; rs1_id = 5'd4; rs1_used_id = 1'b1;
        chk_ctrl("ldst_ctrl", 5'b00000);
        tick();
        chk("ldst_fwd1", forward_1, 2'b01);
        chk("ldst_state_back", state_dbg, S_RUN);

        // branch together with load-use: flush only
        idle();
        rd_ex = 5'd4; regwen_ex = 1'b1; memread_ex = 1'b1;
        rs1_id = 5'd4; rs1_used_id = 1'b1; branch_taken_ex = 1'b1;
        chk_ctrl("br_lu_ctrl", 5'b00110);
        tick();
        chk("br_flcnt", flush_cnt, 16'd1);
        chk("br_ldcnt", ldstall_cnt, 16'd1);
        chk("br_state", state_dbg, S_RUN);
        chk("br_fwd1", forward_1, 2'b00);

        // freeze during LDSTALL
        branch_taken_ex = 1'b0;
        tick();
        chk("frz_pre_ldcnt", ldstall_cnt, 16'd2);
        chk("frz_pre_state", state_dbg, S_LDSTALL);
        idle();
        rd_m = 5'd4; regwen_m = 1'b1; rs1_id = 5'd4; rs1_used_id = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) branch_taken_ex = 1'b1;
            else branch_taken_ex = 1'b0;
            chk_ctrl("frz_ctrl", 5'b00001);
            tick();
            chk("frz_state", state_dbg, S_FRZ);
            chk("frz_fwd1_hold", forward_1, 2'b00);
            chk("frz_ldcnt_hold", ldstall_cnt, 16'd2);
            chk("frz_flcnt_hold", flush_cnt, 16'd1);
        end
        branch_taken_ex = 1'b0;
        mem_busy = 1'b0;
        chk_ctrl("frz_release_ctrl", 5'b00000);
        tick();
        chk("frz_resume_state", state_dbg, S_LDSTALL);
        chk("frz_resume_fwd1", forward_1, 2'b01);
        tick();
        chk("frz_then_run", state_dbg, S_RUN);

        // freeze holds a non-zero forward select
        idle();
        rd_ex = 5'd9; regwen_ex = 1'b1; rs2_id = 5'd9; rs2_used_id = 1'b1;
        tick();
        chk("hold_pre_fwd2", forward_2, 2'b10);
        rd_ex = 5'd0; rd_m = 5'd9; regwen_m = 1'b1; mem_busy = 1'b1;
        tick();
        chk("hold_fwd2", forward_2, 2'b10);

        // reset mid-freeze: back to RUN, nothing saved
        rst_n = 1'b0;
        chk_ctrl("rst_frz_ctrl", 5'b00000);
        tick();
        chk("rst_frz_state", state_dbg, S_RUN);
        chk("rst_frz_fwd2", forward_2, 2'b00);
        chk("rst_frz_ldcnt", ldstall_cnt, 16'd0);
        chk("rst_frz_flcnt", flush_cnt, 16'd0);
        rst_n = 1'b1;
        idle();
        tick();
        chk("rst_frz_after", state_dbg, S_RUN);

        // x0 never matches
        rs1_id = 5'd0; rs1_used_id = 1'b1; rd_ex = 5'd0; regwen_ex = 1'b1;
        rd_m = 5'd0; regwen_m = 1'b1; memread_ex = 1'b1;
        chk_ctrl("x0_no_stall", 5'b00000);
        tick();
        chk("x0_fwd1", forward_1, 2'b00);
        chk("x0_ldcnt", ldstall_cnt, 16'd0);

        // saturation: hold a load-use every cycle
        idle();
        rd_ex = 5'd4; regwen_ex = 1'b1; memread_ex = 1'b1;
        rs1_id = 5'd4; rs1_used_id = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", ldstall_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", ldstall_cnt, 16'hFFFF);
        tick();
        tick();
        chk("sat_hold", ldstall_cnt, 16'hFFFF);
        chk("sat_flcnt", flush_cnt, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
